// File: rtl/oled_spi_receiver_if.sv
// AHB-Lite slave-side bus bundle for the OLED link receiver.
// The master modport drives the request; the slave modport returns read data and ready.
interface oled_spi_receiver_if;
  logic        HSEL;
  logic        HREADY;
  logic        HWRITE;
  logic [31:0] HADDR;
  logic [31:0] HWDATA;
  logic [2:0]  HSIZE;
  logic [1:0]  HTRANS;
  logic [31:0] HRDATA;
  logic        HREADYOUT;

  modport master (
    output HSEL, HREADY, HWRITE, HADDR, HWDATA, HSIZE, HTRANS,
    input  HRDATA, HREADYOUT
  );

  modport slave (
    input  HSEL, HREADY, HWRITE, HADDR, HWDATA, HSIZE, HTRANS,
    output HRDATA, HREADYOUT
  );
endinterface

// File: rtl/oled_spi_receiver.sv
// Receive side of the OLED serial link: rebuilds MSB-first bytes from nCS/DnC/SDIN/SCLK
// and queues {DnC, byte} entries in a small FIFO read by software over AHB-Lite.
module oled_spi_receiver #(
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                 HCLK,
  input  logic                 HRESETn,
  oled_spi_receiver_if.slave   bus,
  input  logic                 nCS,
  input  logic                 DnC,
  input  logic                 SDIN,
  input  logic                 SCLK,
  output logic                 IRQ
);

  localparam int unsigned PtrW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CntW = PtrW + 1;
  localparam logic [CntW-1:0] DepthC = CntW'(FIFO_DEPTH);

  typedef enum logic {StIdle, StShift} state_e;

  // Link line sampling
  logic ncs_r, dnc_r, sdin_r, sclk_r, sclk_p;
  logic enable_q;
  logic bit_evt;

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      ncs_r  <= 1'b1;
      dnc_r  <= 1'b0;
      sdin_r <= 1'b0;
      sclk_r <= 1'b0;
      sclk_p <= 1'b0;
    end else begin
      ncs_r  <= nCS;
      dnc_r  <= DnC;
      sdin_r <= SDIN;
      sclk_r <= SCLK;
      sclk_p <= sclk_r;
    end
  end

  assign bit_evt = sclk_r & ~sclk_p & ~ncs_r & enable_q;

  // Byte assembly FSM
  state_e      state_q, state_d;
  logic [2:0]  bit_cnt_q, bit_cnt_d;
  logic [7:0]  shift_q;
  logic        byte_done;
  logic        frame_err_set;
  logic        push_q;
  logic [8:0]  push_data_q;

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state_q   <= StIdle;
      bit_cnt_q <= 3'd0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle: begin
        if (bit_evt) state_d = StShift;
      end
      StShift: begin
        if (!enable_q || ncs_r) begin
          state_d = StIdle;
        end else if (bit_evt && (bit_cnt_q == 3'd7)) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    byte_done     = 1'b0;
    frame_err_set = 1'b0;
    bit_cnt_d     = bit_cnt_q;
    case (state_q)
      StIdle: begin
        bit_cnt_d = bit_evt ? 3'd1 : 3'd0;
      end
      StShift: begin
        // Dropping enable abandons the byte quietly; only a premature nCS is a framing error.
        frame_err_set = enable_q & ncs_r;
        byte_done     = bit_evt & (bit_cnt_q == 3'd7);
        if (!enable_q || ncs_r || byte_done) begin
          bit_cnt_d = 3'd0;
        end else if (bit_evt) begin
          bit_cnt_d = bit_cnt_q + 3'd1;
        end
      end
      default: bit_cnt_d = 3'd0;
    endcase
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      shift_q     <= 8'h00;
      push_q      <= 1'b0;
      push_data_q <= 9'h000;
    end else begin
      if (bit_evt) shift_q <= {shift_q[6:0], sdin_r};
      push_q <= byte_done;
      if (byte_done) push_data_q <= {dnc_r, shift_q[6:0], sdin_r};
    end
  end

  // AHB-Lite address/data phase
  logic       acc;
  logic       dp_valid_q, dp_write_q;
  logic [1:0] dp_addr_q;

  assign acc = bus.HSEL & bus.HREADY & (bus.HTRANS != 2'b00);

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      dp_valid_q <= 1'b0;
      dp_write_q <= 1'b0;
      dp_addr_q  <= 2'd0;
    end else if (bus.HREADY) begin
      dp_valid_q <= acc;
      dp_write_q <= bus.HWRITE;
      dp_addr_q  <= bus.HADDR[3:2];
    end
  end

  logic rd_data_cyc, wr_status, wr_ctrl;
  assign rd_data_cyc = dp_valid_q & ~dp_write_q;
  assign wr_status   = dp_valid_q & dp_write_q & (dp_addr_q == 2'd1);
  assign wr_ctrl     = dp_valid_q & dp_write_q & (dp_addr_q == 2'd2);

  // FIFO
  logic [8:0]      mem_q [FIFO_DEPTH];
  logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0] count_q;
  logic            not_empty, full, pop, push_ok, ovf_set;

  assign not_empty = (count_q != '0);
  assign full      = (count_q == DepthC);
  assign pop       = rd_data_cyc & (dp_addr_q == 2'd0) & not_empty;
  // A pop on the same edge frees a slot, so a push into a full FIFO still lands.
  assign push_ok   = push_q & (~full | pop);
  assign ovf_set   = push_q & full & ~pop;

  always_ff @(posedge HCLK) begin
    if (push_ok) mem_q[wr_ptr_q] <= push_data_q;
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)     rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({push_ok, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  // Sticky flags and control
  logic overflow_q, frame_err_q;

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      overflow_q  <= 1'b0;
      frame_err_q <= 1'b0;
      enable_q    <= 1'b1;
    end else begin
      if (ovf_set) begin
        overflow_q <= 1'b1;
      end else if (wr_status && bus.HWDATA[2]) begin
        overflow_q <= 1'b0;
      end
      if (frame_err_set) begin
        frame_err_q <= 1'b1;
      end else if (wr_status && bus.HWDATA[3]) begin
        frame_err_q <= 1'b0;
      end
      if (wr_ctrl) enable_q <= bus.HWDATA[0];
    end
  end

  // Read data
  logic [3:0]  count4;
  logic [31:0] status_word;

  assign count4      = 4'(count_q);
  assign status_word = {24'h000000, count4, frame_err_q, overflow_q, full, not_empty};

  always_comb begin
    bus.HRDATA = 32'h0000_0000;
    if (rd_data_cyc) begin
      case (dp_addr_q)
        2'd0:    if (not_empty) bus.HRDATA = {23'h000000, mem_q[rd_ptr_q]};
        2'd1:    bus.HRDATA = status_word;
        2'd2:    bus.HRDATA = {31'h00000000, enable_q};
        default: bus.HRDATA = 32'h0000_0000;
      endcase
    end
  end

  assign bus.HREADYOUT = 1'b1;
  assign IRQ           = not_empty & enable_q;

  logic unused_bus_bits;
  assign unused_bus_bits = ^{bus.HSIZE, bus.HADDR[31:4], bus.HADDR[1:0],
                             bus.HWDATA[31:4], bus.HWDATA[1]};

endmodule

// File: tb/tb_oled_spi_receiver.sv
// Self-checking bench for oled_spi_receiver: drives the serial link in oled_manager style
// and checks AHB reads against a queue-based model of the FIFO and status flags.
module tb_oled_spi_receiver;

  localparam int unsigned Depth = 4;
  localparam int         Half  = 2;

  logic HCLK = 1'b0;
  logic HRESETn = 1'b0;
  logic nCS = 1'b1, DnC = 1'b0, SDIN = 1'b0, SCLK = 1'b0;
  logic IRQ;

  oled_spi_receiver_if bus ();

  oled_spi_receiver #(.FIFO_DEPTH(Depth)) dut (
    .HCLK    (HCLK),
    .HRESETn (HRESETn),
    .bus     (bus),
    .nCS     (nCS),
    .DnC     (DnC),
    .SDIN    (SDIN),
    .SCLK    (SCLK),
    .IRQ     (IRQ)
  );

  always #5 HCLK = ~HCLK;

  int n_cmp = 0;
  int n_err = 0;

  // Model state
  logic [31:0] sb_q[$];
  bit m_ovf = 1'b0, m_frame = 1'b0, m_en = 1'b1;

  typedef struct {
    logic       dnc;
    logic [7:0] data;
    logic [31:0] exp;
  } vec_t;
  vec_t vecs [16];

  task automatic tick(input int n);
    repeat (n) @(posedge HCLK);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] exp_status();
    int c = sb_q.size();
    return {24'h0, 4'(c), m_frame, m_ovf, (c == Depth), (c != 0)};
  endfunction

  task automatic ahb_read(input logic [31:0] addr, output logic [31:0] data);
    bus.HSEL = 1'b1; bus.HTRANS = 2'b10; bus.HWRITE = 1'b0; bus.HADDR = addr;
    tick(1);
    bus.HSEL = 1'b0; bus.HTRANS = 2'b00;
    data = bus.HRDATA;
    tick(1);
  endtask

  task automatic ahb_write(input logic [31:0] addr, input logic [31:0] data);
    bus.HSEL = 1'b1; bus.HTRANS = 2'b10; bus.HWRITE = 1'b1; bus.HADDR = addr;
    tick(1);
    bus.HSEL = 1'b0; bus.HTRANS = 2'b00; bus.HWRITE = 1'b0; bus.HWDATA = data;
    tick(1);
  endtask

  task automatic check_status(input string name);
    logic [31:0] d;
    ahb_read(32'h4, d);
    check(name, d, exp_status());
  endtask

  task automatic pop_check(input string name);
    logic [31:0] d, e;
    ahb_read(32'h0, d);
    e = (sb_q.size() != 0) ? sb_q.pop_front() : 32'h0;
    check(name, d, e);
  endtask

  task automatic model_push(input logic [31:0] e);
    if (!m_en) return;
    if (sb_q.size() < Depth) sb_q.push_back(e);
    else m_ovf = 1'b1;
  endtask

  task automatic drive_bit(input logic b);
    SDIN = b; SCLK = 1'b0;
    tick(Half);
    SCLK = 1'b1;
    tick(Half);
  endtask

  task automatic send_bits(input logic dnc, input logic [7:0] data, input int n);
    nCS = 1'b0; DnC = dnc;
    for (int i = 0; i < n; i++) drive_bit(data[7-i]);
  endtask

  task automatic end_frame();
    SCLK = 1'b0;
    tick(1);
    nCS = 1'b1;
    tick(4);
  endtask

  task automatic send_byte(input logic dnc, input logic [7:0] data);
    send_bits(dnc, data, 8);
    end_frame();
    model_push({23'h0, dnc, data});
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] d;
    logic [7:0]  b;
    bus.HSEL = 1'b0; bus.HREADY = 1'b1; bus.HWRITE = 1'b0; bus.HADDR = '0;
    bus.HWDATA = '0; bus.HSIZE = 3'b010; bus.HTRANS = 2'b00;

    for (int i = 0; i < 16; i++) begin
      vecs[i].dnc  = 1'($urandom_range(0, 1));
      vecs[i].data = 8'($urandom_range(0, 255));
    end
    vecs[0].dnc = 1'b0; vecs[0].data = 8'h00;
    vecs[1].dnc = 1'b1; vecs[1].data = 8'hFF;
    vecs[2].dnc = 1'b0; vecs[2].data = 8'h80;
    vecs[3].dnc = 1'b1; vecs[3].data = 8'h01;
    for (int i = 0; i < 16; i++) vecs[i].exp = {23'h0, vecs[i].dnc, vecs[i].data};

    // Reset state
    tick(2);
    check("rst_hreadyout", {31'h0, bus.HREADYOUT}, 32'h1);
    check("rst_irq", {31'h0, IRQ}, 32'h0);
    check("rst_hrdata", bus.HRDATA, 32'h0);
    HRESETn = 1'b1;
    tick(2);
    check_status("rst_status");
    ahb_read(32'h8, d);
    check("rst_ctrl", d, 32'h1);
    pop_check("rst_empty_pop");

    // Single byte
    send_byte(1'b1, 8'hA5);
    check_status("single_status");
    check("single_irq", {31'h0, IRQ}, 32'h1);
    pop_check("single_data");
    check_status("single_status_after");
    check("single_irq_after", {31'h0, IRQ}, 32'h0);
    pop_check("single_empty_pop");
    check_status("single_empty_status");

    // Ordering and overflow
    for (int i = 1; i <= 5; i++) send_byte(1'b0, 8'(i));
    check_status("ovf_status");
    for (int i = 0; i < 4; i++) pop_check("ovf_order");
    ahb_write(32'h4, 32'h4);
    m_ovf = 1'b0;
    check_status("ovf_cleared");

    // Framing error then clean byte
    send_bits(1'b0, 8'hE0, 3);
    end_frame();
    m_frame = 1'b1;
    check_status("frame_status");
    send_byte(1'b0, 8'h3C);
    check_status("frame_next_status");
    pop_check("frame_next_data");
    ahb_write(32'h4, 32'h8);
    m_frame = 1'b0;
    check_status("frame_cleared");

    // Pop and push on the same edge with the FIFO full
    for (int i = 0; i < 4; i++) send_byte(1'b0, 8'(8'h10 + i));
    b = 8'h77;
    send_bits(1'b1, b, 7);
    SDIN = b[0]; SCLK = 1'b0;
    tick(Half);
    SCLK = 1'b1;
    tick(1);
    bus.HSEL = 1'b1; bus.HTRANS = 2'b10; bus.HWRITE = 1'b0; bus.HADDR = 32'h0;
    tick(1);
    bus.HSEL = 1'b0; bus.HTRANS = 2'b00;
    d = bus.HRDATA;
    tick(1);
    check("conc_pop", d, sb_q.pop_front());
    sb_q.push_back({23'h0, 1'b1, b});
    tick(1);
    end_frame();
    check_status("conc_status");
    for (int i = 0; i < 4; i++) pop_check("conc_drain");

    // Enable cleared mid-byte
    send_bits(1'b0, 8'h99, 4);
    ahb_write(32'h8, 32'h0);
    m_en = 1'b0;
    ahb_read(32'h8, d);
    check("ctrl_off", d, 32'h0);
    for (int i = 4; i < 8; i++) drive_bit(1'b1);
    end_frame();
    check_status("disabled_status");
    ahb_write(32'h8, 32'h1);
    m_en = 1'b1;
    send_byte(1'b1, 8'h5A);
    check_status("reenable_status");
    pop_check("reenable_data");

    // Reset mid-byte
    send_byte(1'b0, 8'hEE);
    check("pre_rst_irq", {31'h0, IRQ}, 32'h1);
    send_bits(1'b1, 8'hF0, 4);
    #2 HRESETn = 1'b0;
    #1;
    check("mid_rst_hreadyout", {31'h0, bus.HREADYOUT}, 32'h1);
    check("mid_rst_irq", {31'h0, IRQ}, 32'h0);
    check("mid_rst_hrdata", bus.HRDATA, 32'h0);
    sb_q.delete(); m_ovf = 1'b0; m_frame = 1'b0; m_en = 1'b1;
    tick(2);
    HRESETn = 1'b1;
    nCS = 1'b1; SCLK = 1'b0;
    tick(3);
    check_status("post_rst_status");
    ahb_read(32'h8, d);
    check("post_rst_ctrl", d, 32'h1);

    // Loopback table with drain reads
    for (int i = 0; i < 16; i++) begin
      send_bits(vecs[i].dnc, vecs[i].data, 8);
      end_frame();
      model_push(vecs[i].exp);
      if (i % 2 == 1) begin
        pop_check("loop_data");
        pop_check("loop_data");
      end
    end
    check_status("loop_final_status");
    check("loop_final_irq", {31'h0, IRQ}, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/oled_spi_receiver.md
Name: oled_spi_receiver

Overview:
- Receive-side counterpart of the OLED serial link: samples nCS/DnC/SDIN/SCLK and rebuilds 8-bit packets, MSB first, one packet per byte.
- Stores each packet plus its DnC flag in a small FIFO that software reads over AHB-Lite.
- Used as an on-chip loopback monitor for oled_manager traffic and as a display-side model in SoC simulation.
- Link inputs are synchronous to HCLK; no CDC logic.

Parameters:
- FIFO_DEPTH, 4, number of {DnC, byte} entries; power of 2, range 2..8.

Ports:
- HCLK  in  1  system clock
- HRESETn  in  1  asynchronous active-low reset
- HSEL  in  1  AHB slave select
- HREADY  in  1  AHB bus ready
- HWRITE  in  1  AHB write
- HADDR  in  32  address; only [3:2] decoded
- HWDATA  in  32  write data
- HSIZE  in  3  word transfers only; ignored
- HTRANS  in  2  transfer type; 00 = no transfer
- HRDATA  out  32  read data
- HREADYOUT  out  1  always 1; no wait states
- nCS  in  1  link chip select, active low
- DnC  in  1  link data(1)/command(0)
- SDIN  in  1  link serial data
- SCLK  in  1  link serial clock
- IRQ  out  1  high while FIFO not empty and enabled

Behaviour:
- Clock and reset: one clock HCLK. Reset HRESETn is asynchronous, active-low.
- Reset values: FIFO empty, pointers 0, bit counter 0, shift reg 0, sticky flags 0, enable 1, HRDATA 0, HREADYOUT 1, IRQ 0.
- Memory map:
  - 0x0: RX data, read-pops; returns {23'b0, dnc, byte}. Writes ignored.
  - 0x4: status, read: [0] not_empty, [1] full, [2] overflow (sticky), [3] frame_err (sticky), [7:4] count. Write: 1 in [2]/[3] clears that flag.
  - 0x8: control [0] enable, read/write.
  - Other addresses: read 0, writes ignored.
- AHB: the address phase is accepted when HREADY & HSEL & HTRANS!=00. Decode is registered. Read data is driven combinationally in the next (data) cycle. Write data is captured at the end of the data cycle. A pop takes effect at the end of the data cycle.
- Line sampling: nCS/DnC/SDIN/SCLK are registered once (stage r), and sclk_r is delayed once more (sclk_p). A bit event is sclk_r & !sclk_p & !ncs_r & enable. Each bit event shifts sdin_r into the LSB, so the first bit received ends up as bit 7.
- State machine:
  - Idle: the bit counter is 0. A bit event moves to Shift with count 1.
  - Shift: each bit event increments the count.
  - On the 8th bit event: push {dnc_r, byte} (dnc_r sampled at the 8th bit), clear the count, return to Idle.
  - ncs_r high while in Shift: discard the partial byte, set frame_err, go to Idle.
- Latency: the FIFO count increments on the 2nd HCLK rising edge after the edge that first samples SCLK=1 for bit 8.
- Full: a push while count==FIFO_DEPTH drops the new byte, sets overflow, and leaves FIFO contents unchanged.
- Empty: a pop of 0x0 while empty returns 0 and leaves pointers unchanged.
- Push and pop in the same cycle: both are performed and count is unchanged. When the FIFO is full, the pop frees space first, so the push succeeds with no overflow.
- Pointers wrap modulo FIFO_DEPTH. Count is FIFO_DEPTH+1 values wide.
- Enable=0: no bit events, counter forced to 0, FIFO still readable. Clearing enable mid-byte discards the partial byte with no frame_err.
- Simultaneous clear-write and a new error in the same cycle: the set wins.
- Reset mid-byte or mid-transfer: all state returns to reset values immediately. The next byte is received cleanly only once nCS has been high at least once after reset.

Test Plan:
- Single byte: drive 0xA5 with DnC=1 in oled_manager timing → status reads 0x11, IRQ=1, read 0x0 = 0x000001A5, then status=0x00, IRQ=0.
- Ordering and overflow: send 0x01..0x05 with DnC=0 and no reads → status = 0x47 (count 4, full, overflow, not empty); reads return 0x01..0x04; then write 0x4 with 0x4 → overflow clears.
- Framing: nCS low for 3 SCLK pulses then high → frame_err=1, count 0. The following full byte 0x3C is received correctly.
- Concurrency: with the FIFO full, issue a read whose pop lands on the same edge as a push of 0x77 → count stays 4, no overflow, 0x77 is last out.
- Control: enable=0 during a byte → nothing pushed. Re-enable → next byte 0x5A received. Reset asserted mid-byte → all status 0, HREADYOUT=1.
- Loopback: connect oled_manager outputs to the receiver and write 16 random {DnC, byte} pairs with drain reads → every read matches the written pair.
